// File: rtl/key_event_decoder.sv
// key_event_decoder: filters the two raw HID keycode bytes and turns them
// into held / press / release / auto-repeat signals for eight game keys.
module key_event_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY  = 30,
    parameter int unsigned REPEAT_RATE   = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic       frame_tick,
    output logic [7:0] held,
    output logic [7:0] press_pulse,
    output logic [7:0] release_pulse,
    output logic [7:0] repeat_pulse,
    output logic       rollover
);

    // Usage codes of the tracked keys, bit i of the outputs <-> byte i here.
    localparam logic [63:0] CODES = {8'h51, 8'h52, 8'h28, 8'h2C,
                                     8'h07, 8'h16, 8'h04, 8'h1A};
    localparam logic [7:0] ERR_ROLL = 8'h01;
    localparam logic [7:0] STB      = 8'(STABLE_CYCLES);
    localparam logic [7:0] STB_M1   = 8'(STABLE_CYCLES - 1);
    localparam logic [8:0] DLY      = 9'(REPEAT_DELAY);
    localparam logic [7:0] RELOAD   = 8'(REPEAT_DELAY - REPEAT_RATE);

    logic [15:0] raw;
    logic [15:0] last_raw_q, last_raw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  acc0_q, acc0_d;
    logic [7:0]  acc1_q, acc1_d;
    logic [7:0]  cur;
    logic [7:0]  held_q, held_d;
    logic [7:0]  press_q, press_d;
    logic [7:0]  rel_q, rel_d;
    logic [7:0]  rep_q, rep_d;
    logic [7:0]  rc_q [8];
    logic [7:0]  rc_d [8];
    logic        raw_roll;

    assign raw      = {keycode1, keycode0};
    assign raw_roll = (keycode0 == ERR_ROLL) || (keycode1 == ERR_ROLL);

    // Stability window: accept a pair only after it sat unchanged long enough.
    always_comb begin
        last_raw_d = raw;
        cnt_d      = cnt_q;
        acc0_d     = acc0_q;
        acc1_d     = acc1_q;
        if (raw != last_raw_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q < STB) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (cnt_q == STB_M1 && !raw_roll) begin
                acc0_d = keycode0;
                acc1_d = keycode1;
            end
        end
    end

    // Decode accepted pair into key bitmap and derive edge pulses.
    always_comb begin
        cur = '0;
        for (int i = 0; i < 8; i++) begin
            cur[i] = (acc0_q == CODES[8*i +: 8]) ||
                     (acc1_q == CODES[8*i +: 8]);
        end
        held_d  = cur;
        press_d = cur & ~held_q;
        rel_d   = ~cur & held_q;
    end

    // Per-key auto-repeat counters paced by frame ticks.
    always_comb begin
        rep_d = '0;
        for (int i = 0; i < 8; i++) begin
            rc_d[i] = rc_q[i];
            if (!held_q[i] || press_q[i]) begin
                rc_d[i] = '0;
            end else if (frame_tick) begin
                if ({1'b0, rc_q[i]} + 9'd1 == DLY) begin
                    rep_d[i] = 1'b1;
                    rc_d[i]  = RELOAD;
                end else begin
                    rc_d[i] = rc_q[i] + 8'd1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_raw_q <= '0;
            cnt_q      <= '0;
            acc0_q     <= '0;
            acc1_q     <= '0;
            held_q     <= '0;
            press_q    <= '0;
            rel_q      <= '0;
            rep_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                rc_q[i] <= '0;
            end
        end else begin
            last_raw_q <= last_raw_d;
            cnt_q      <= cnt_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            held_q     <= held_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            rep_q      <= rep_d;
            for (int i = 0; i < 8; i++) begin
                rc_q[i] <= rc_d[i];
            end
        end
    end

    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign repeat_pulse  = rep_q;
    assign rollover      = (last_raw_q[7:0] == ERR_ROLL) ||
                           (last_raw_q[15:8] == ERR_ROLL);

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios with literal expectations
// plus randomized keycode traffic compared against a behavioural model.
module tb_key_event_decoder;

    localparam int S = 4;
    localparam int D = 30;
    localparam int R = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] k0, k1;
    logic       ft;
    logic [7:0] held, press, rel, rep;
    logic       roll;

    key_event_decoder #(
        .STABLE_CYCLES(S),
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .keycode0     (k0),
        .keycode1     (k1),
        .frame_tick   (ft),
        .held         (held),
        .press_pulse  (press),
        .release_pulse(rel),
        .repeat_pulse (rep),
        .rollover     (roll)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] CODE [8] = '{8'h1A, 8'h04, 8'h16, 8'h07,
                             8'h2C, 8'h28, 8'h52, 8'h51};

    // model state
    logic [7:0]  m_acc0, m_acc1;
    logic [7:0]  m_held, m_press, m_rel, m_rep;
    logic [15:0] m_prev;
    int          m_run;
    int          m_n [8];

    function automatic logic [7:0] keys_of(logic [7:0] a, logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = (a == CODE[i]) || (b == CODE[i]);
        end
        return r;
    endfunction

    // n-th tick counted since the press: first at D, then every R ticks
    function automatic bit rep_due(int n);
        return (n == D) || (n > D && ((n - D) % R) == 0);
    endfunction

    task automatic model_step();
        logic [7:0] cur;
        logic [7:0] nrep;
        if (rst) begin
            m_acc0 = '0; m_acc1 = '0;
            m_held = '0; m_press = '0; m_rel = '0; m_rep = '0;
            m_prev = '0; m_run = 1;
            for (int i = 0; i < 8; i++) m_n[i] = 0;
        end else begin
            cur  = keys_of(m_acc0, m_acc1);
            nrep = '0;
            for (int i = 0; i < 8; i++) begin
                if (!m_held[i] || m_press[i]) begin
                    m_n[i] = 0;
                end else if (ft) begin
                    m_n[i]  = m_n[i] + 1;
                    nrep[i] = rep_due(m_n[i]);
                end
            end
            m_rel   = ~cur & m_held;
            m_press = cur & ~m_held;
            m_held  = cur;
            m_rep   = nrep;
            if ({k1, k0} == m_prev) begin
                if (m_run < S + 2) m_run = m_run + 1;
            end else begin
                m_run = 1;
            end
            m_prev = {k1, k0};
            if (m_run == S + 1 && k0 != 8'h01 && k1 != 8'h01) begin
                m_acc0 = k0;
                m_acc1 = k1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check8("mdl_held", held, m_held);
            check8("mdl_press", press, m_press);
            check8("mdl_release", rel, m_rel);
            check8("mdl_repeat", rep, m_rep);
            check1("mdl_rollover", roll,
                   (m_prev[7:0] == 8'h01) || (m_prev[15:8] == 8'h01));
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] pick_code();
        int unsigned r;
        r = $urandom_range(0, 11);
        if (r < 8) return CODE[r];
        if (r == 8) return 8'h01;
        if (r == 9) return 8'h99;
        return 8'h00;
    endfunction

    initial begin
        logic [7:0] a, b;
        int len;
        rst = 1'b1; k0 = '0; k1 = '0; ft = 1'b0;
        step(3);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check8("reset_held", held, 8'h00);
        check8("reset_press", press, 8'h00);
        check1("reset_roll", roll, 1'b0);

        // W press latency
        step(4);
        k0 = 8'h1A;
        step(5);
        @(negedge clk);
        check8("w_early_held", held, 8'h00);
        step(1);
        @(negedge clk);
        check8("w_held", held, 8'h01);
        check8("w_press", press, 8'h01);
        check8("w_model_held", m_held, 8'h01);
        step(1);
        @(negedge clk);
        check8("w_press_gone", press, 8'h00);
        check8("w_held_stays", held, 8'h01);

        // D + Space, then Space released
        step(1);
        k0 = 8'h07; k1 = 8'h2C;
        step(6);
        @(negedge clk);
        check8("dsp_held", held, 8'h18);
        step(1);
        k1 = 8'h00;
        step(6);
        @(negedge clk);
        check8("d_held", held, 8'h08);
        check8("sp_release", rel, 8'h10);
        step(1);
        @(negedge clk);
        check8("sp_release_gone", rel, 8'h00);

        // glitching A never accepted
        step(1);
        k0 = 8'h00; k1 = 8'h00;
        step(10);
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) k0 = (c % 4 == 0) ? 8'h04 : 8'h00;
            @(negedge clk);
            check8("glitch_held", held, 8'h00);
            check8("glitch_press", press, 8'h00);
            step(1);
        end

        // Up auto-repeat
        k0 = 8'h52;
        step(8);
        for (int t = 1; t <= 50; t++) begin
            ft = 1'b1;
            step(1);
            ft = 1'b0;
            @(negedge clk);
            check8("up_repeat", rep,
                   (t == 30 || t == 36 || t == 42 || t == 48) ? 8'h40 : 8'h00);
            step(1);
        end

        // rollover with S held
        k0 = 8'h16; k1 = 8'h00;
        step(8);
        @(negedge clk);
        check8("s_held", held, 8'h04);
        step(1);
        k1 = 8'h01;
        step(1);
        @(negedge clk);
        check1("roll_on", roll, 1'b1);
        check8("roll_held", held, 8'h04);
        step(10);
        @(negedge clk);
        check1("roll_stays", roll, 1'b1);
        check8("roll_held_late", held, 8'h04);
        step(1);
        k1 = 8'h00;
        step(1);
        @(negedge clk);
        check1("roll_off", roll, 1'b0);
        step(10);
        @(negedge clk);
        check8("post_roll_held", held, 8'h04);
        check8("post_roll_press", press, 8'h00);

        // reset while D held
        step(1);
        k0 = 8'h07;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check8("rst_held", held, 8'h00);
        check8("rst_press", press, 8'h00);
        check8("rst_rel", rel, 8'h00);
        check8("rst_rep", rep, 8'h00);
        check1("rst_roll", roll, 1'b0);
        step(5);
        @(negedge clk);
        check8("rst_d_early", press, 8'h00);
        step(1);
        @(negedge clk);
        check8("rst_d_press", press, 8'h08);
        check8("rst_d_held", held, 8'h08);

        // randomized traffic
        step(1);
        repeat (400) begin
            a = pick_code();
            b = ($urandom_range(0, 1) == 0) ? 8'h00 : pick_code();
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(100, 250))
                                              : int'($urandom_range(1, 10));
            k0 = a; k1 = b;
            repeat (len) begin
                ft  = ($urandom_range(0, 1) == 0);
                rst = ($urandom_range(0, 399) == 0);
                step(1);
            end
        end
        rst = 1'b0; ft = 1'b0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
